// File: rtl/c17_result_collector_if.sv
// Handshake and netlist-facing bundle for c17_result_collector.
// slave modport: collector side. master modport: upstream/consumer/netlist side.
interface c17_result_collector_if #(
  parameter int DEPTH = 8
) ();
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_data;
  logic [4:0]    net_in;
  logic [1:0]    net_out;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_data;
  logic [LW-1:0] level;
  logic          mismatch;

  modport slave (
    input  in_valid, in_data, net_out, out_ready,
    output in_ready, net_in, out_valid, out_data, level, mismatch
  );

  modport master (
    output in_valid, in_data, net_out, out_ready,
    input  in_ready, net_in, out_valid, out_data, level, mismatch
  );
endinterface

// File: rtl/c17_result_collector.sv
// Collection stage for the path-balanced c17 netlist: launches vectors,
// tracks them with a LATENCY-deep valid tag and captures results into a
// DEPTH-entry FIFO. Credits (level) reserve a FIFO slot for every launched
// vector, so capture never has to be refused.
// Optional golden-model checker enabled by defining C17_COLLECT_CHECK_EN.
module c17_result_collector #(
  parameter int LATENCY = 5,
  parameter int DEPTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  c17_result_collector_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [LATENCY:1] tag_q;
  logic [4:0]       net_in_q;
  logic [AW:0]      level_q, level_d;
  logic [AW:0]      wr_q, rd_q;
  logic [1:0]       mem_q [DEPTH];
  logic             launch, pop, capture, fifo_nempty;

  assign bus.in_ready  = (level_q < FULL_LVL);
  assign launch        = bus.in_valid && bus.in_ready;
  assign fifo_nempty   = (wr_q != rd_q);
  assign pop           = fifo_nempty && bus.out_ready;
  assign capture       = tag_q[LATENCY];

  assign bus.net_in    = net_in_q;
  assign bus.out_valid = fifo_nempty;
  // Head read straight from storage; gated so stale contents never show while empty.
  assign bus.out_data  = fifo_nempty ? mem_q[rd_q[AW-1:0]] : 2'b00;
  assign bus.level     = level_q;

  // Credit next-state: launch reserves a slot, pop releases one.
  always_comb begin
    level_d = level_q;
    if (launch && !pop)      level_d = level_q + 1'b1;
    else if (!launch && pop) level_d = level_q - 1'b1;
  end

  // Launch register and valid-tag shift register tracking in-flight vectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q    <= '0;
      net_in_q <= '0;
    end else begin
      tag_q[1] <= launch;
      for (int i = 2; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];
      net_in_q <= launch ? bus.in_data : 5'b0;
    end
  end

  // FIFO pointers (extra MSB distinguishes full from empty) and credit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (capture) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      level_q <= level_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (capture) mem_q[wr_q[AW-1:0]] <= bus.net_out;
  end

`ifdef C17_COLLECT_CHECK_EN
  logic [1:0] exp_q [LATENCY:1];
  logic       mismatch_q;

  function automatic logic [1:0] c17_golden(input logic [4:0] v);
    logic n1, n2, n3, n6, n7, n22, n23;
    {n1, n2, n3, n6, n7} = v;
    n22 = (n1 & n3) | (n2 & ~(n3 & n6));
    n23 = ~(n3 & n6) & (n2 | n7);
    return {n23, n22};
  endfunction

  // Expected-result pipeline alongside the tag, and sticky compare at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= LATENCY; i++) exp_q[i] <= 2'b00;
      mismatch_q <= 1'b0;
    end else begin
      exp_q[1] <= c17_golden(bus.in_data);
      for (int i = 2; i <= LATENCY; i++) exp_q[i] <= exp_q[i-1];
      if (capture && (bus.net_out != exp_q[LATENCY])) mismatch_q <= 1'b1;
    end
  end

  assign bus.mismatch = mismatch_q;
`else
  assign bus.mismatch = 1'b0;
`endif
endmodule

// File: doc/c17_result_collector.md
# c17_result_collector

Downstream collection stage for the path-balanced c17 netlist. The netlist advances one level per clock and cannot stall, so this block does three things: it launches 5-bit input vectors into the netlist, tracks them with a LATENCY-deep valid tag, and captures the 2-bit results into a DEPTH-entry FIFO with a valid/ready consumer interface. Credit accounting guarantees that every in-flight result has a FIFO slot reserved, so the FIFO never overflows.

## Interface
- LATENCY, 5, clock cycles from net_in launch to net_out valid (balanced c17 depth); legal range 1..15
- DEPTH, 8, result FIFO entries; power of two, 2..64
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream vector valid
- in_ready  out  1  block can accept a vector this cycle
- in_data  in  5  {N1,N2,N3,N6,N7}, bit 4 = N1
- net_in  out  5  vector driven into netlist inputs, same bit order
- net_out  in  2  {N23,N22} from netlist outputs, bit 0 = N22
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  2  FIFO head {N23,N22}
- level  out  $clog2(DEPTH)+1  reserved credits (in-flight + stored)
- mismatch  out  1  sticky golden-model mismatch flag (see Configuration)

## Operation
- Reset: all outputs low except in_ready, which is high. net_in=0, out_valid=0, out_data=0, level=0, mismatch=0. Tag pipeline, FIFO pointers and credits are cleared.
- Launch:
  - Launch occurs when in_valid && in_ready.
  - net_in is registered; it takes in_data on a launch and 5'b0 on all other cycles (bubble).
  - A tag bit of 1 enters the LATENCY-stage shift register on a launch; 0 otherwise.
- in_ready is combinational: level < DEPTH.
- Capture: when the tag exits stage LATENCY, net_out is written to the FIFO tail. Capture cannot be refused.
- Pop: occurs when out_valid && out_ready. out_data shows the head combinationally from FIFO storage.
- Credits (level):
  - +1 on launch, -1 on pop; unchanged when both occur in the same cycle.
  - Capture does not change level.
- Simultaneous capture and pop are legal, including when the FIFO is empty. In that case the captured entry becomes the head on the next cycle; there is no fall-through.
- Pointers wrap modulo DEPTH. Stored count = wr - rd, computed with one extra pointer bit, so full and empty are distinguishable.

## Timing
- Launch at cycle t: net_in is valid at t+1, and capture is sampled at the edge ending cycle t+LATENCY.
- out_valid first rises at t+LATENCY+1 (empty FIFO case).
- Throughput is one vector per cycle when the consumer is always ready.
- Full: with level==DEPTH, in_ready=0. A pop in the same cycle does not raise in_ready until the next cycle, because in_ready uses registered level.
- Reset asserted mid-operation drops all in-flight and stored results immediately (asynchronous). The first legal launch is the first rising edge after deassertion.

## Configuration
- C17_COLLECT_CHECK_EN defined:
  - An internal golden model computes N22=(N1&N3)|(N2&~(N3&N6)) and N23=~(N3&N6)&(N2|N7) from each launched vector.
  - The expected value is carried in a parallel LATENCY-deep pipeline.
  - It is compared with net_out at capture; any difference sets mismatch, which stays set until reset.
- Undefined: no golden logic is built; mismatch is tied to 0. The port list is identical in both builds.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 → in_ready=1, net_in=0, out_valid=0, level=0. No launch occurs while in reset.
- Single vector: in_data=5'b11111 at t with netlist model attached → out_valid at t+6, out_data=2'b01. Vector 5'b01000 → 2'b11. Vector 5'b00000 → 2'b00.
- Back-pressure: out_ready=0, stream 12 vectors → exactly 8 accepted, in_ready=0 from level 8. Then release out_ready → 8 results pop in launch order, followed by the 4 remaining vectors.
- Concurrent: FIFO empty and one in-flight vector, out_ready=1 → capture and pop never lose or duplicate data. Run 1000 random vectors with random out_ready; the scoreboard matches and level never exceeds 8.
- Mid-run reset: assert rst_n=0 with 3 vectors in flight and 2 stored → outputs return to reset values within the same cycle, and no stale result appears after release.
- Check macro: with C17_COLLECT_CHECK_EN defined, force net_out bit 0 inverted for one capture → mismatch=1 the next cycle and it stays 1. Without the macro, mismatch stays 0.
